// File: rtl/centroid_pkg.sv
// Shared types and constants for the centroid tracker.
package centroid_pkg;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        CHECK,
        DIV_H,
        DIV_V,
        UPDATE
    } state_t;

    localparam logic [11:0] CENTER_H_NONE = 12'hFFF;
    localparam logic [10:0] CENTER_V_NONE = 11'h7FF;

endpackage

// File: rtl/centroid_tracker_seq_divider.sv
// Unsigned restoring divider: start loads operands, done pulses W cycles later.
module seq_divider #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  div_reg;
    logic [CW-1:0] steps;
    logic          busy;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    // The dividend is shifted out of the quotient register as quotient bits shift in.
    always_comb begin
        shifted = {rem, quotient[W-1]};
        diff    = shifted - {1'b0, div_reg};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            div_reg  <= '0;
            quotient <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= '0;
                quotient <= dividend;
                div_reg  <= divisor;
                steps    <= CW'(W);
                busy     <= 1'b1;
            end else if (busy) begin
                if (!diff[W]) begin
                    rem      <= diff[W-1:0];
                    quotient <= {quotient[W-2:0], 1'b1};
                end else begin
                    rem      <= shifted[W-1:0];
                    quotient <= {quotient[W-2:0], 1'b0};
                end
                steps <= steps - CW'(1);
                if (steps == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/centroid_tracker.sv
// Per-frame ball centroid from the binary mask; divides during vertical blanking.
// Optional macro CENTROID_SMOOTH_EN averages consecutive found centres.
module centroid_tracker
    import centroid_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 320,
    parameter int unsigned V_ACTIVE   = 240,
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned ACC_W      = 32
) (
    input  logic        PClk,
    input  logic        Reset,
    input  logic        Binary_in,
    input  logic [11:0] VtcHCnt,
    input  logic [10:0] VtcVCnt,
    output logic [11:0] center_h,
    output logic [10:0] center_v,
    output logic        ball_found,
    output logic [16:0] pixel_count,
    output logic        result_stb,
    output logic        frame_drop
);

    state_t             state;
    logic [ACC_W-1:0]   sum_h;
    logic [ACC_W-1:0]   sum_v;
    logic [16:0]        cnt;
    logic [ACC_W-1:0]   op_v;
    logic [16:0]        op_cnt;
    logic [11:0]        q_h;
    logic               found;
    logic               fs;
    logic               fe;
    logic               active;
    logic               div_start;
    logic [ACC_W-1:0]   div_dividend;
    logic [ACC_W-1:0]   div_divisor;
    logic [ACC_W-1:0]   div_q;
    logic               div_done;
    logic [11:0]        next_h;
    logic [10:0]        next_v;

    // The H divide is launched straight from the live accumulators at frame end,
    // overlapping the CHECK cycle; a not-found frame simply ignores its result.
    always_comb begin
        fs           = (VtcHCnt == 12'd0) && (VtcVCnt == 11'd0);
        fe           = (VtcHCnt == 12'd0) && (VtcVCnt == 11'(V_ACTIVE));
        active       = Binary_in && (VtcHCnt < 12'(H_ACTIVE)) && (VtcVCnt < 11'(V_ACTIVE))
                       && ((state != SYNC) || fs);
        div_start    = (fe && (state == IDLE)) || ((state == DIV_H) && div_done);
        div_dividend = (state == DIV_H) ? op_v : sum_h;
        div_divisor  = (state == DIV_H) ? ACC_W'(op_cnt) : ACC_W'(cnt);
`ifdef CENTROID_SMOOTH_EN
        if (ball_found) begin
            next_h = 12'(({1'b0, center_h} + {1'b0, q_h} + 13'd1) >> 1);
            next_v = 11'(({1'b0, center_v} + {1'b0, 11'(div_q)} + 12'd1) >> 1);
        end else begin
            next_h = q_h;
            next_v = 11'(div_q);
        end
`else
        next_h = q_h;
        next_v = 11'(div_q);
`endif
    end

    seq_divider #(.W(ACC_W)) u_div (
        .clk      (PClk),
        .reset    (Reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_q),
        .done     (div_done)
    );

    always_ff @(posedge PClk) begin
        if (Reset || fe) begin
            sum_h <= '0;
            sum_v <= '0;
            cnt   <= '0;
        end else if (active) begin
            sum_h <= sum_h + ACC_W'(VtcHCnt);
            sum_v <= sum_v + ACC_W'(VtcVCnt);
            if (cnt != '1) cnt <= cnt + 17'd1;
        end
    end

    always_ff @(posedge PClk) begin
        if (Reset) begin
            state       <= SYNC;
            center_h    <= CENTER_H_NONE;
            center_v    <= CENTER_V_NONE;
            ball_found  <= 1'b0;
            pixel_count <= '0;
            result_stb  <= 1'b0;
            frame_drop  <= 1'b0;
            op_v        <= '0;
            op_cnt      <= '0;
            q_h         <= '0;
            found       <= 1'b0;
        end else begin
            result_stb <= 1'b0;
            if (fe && (state != IDLE) && (state != SYNC)) frame_drop <= 1'b1;
            case (state)
                SYNC: if (fs) state <= IDLE;
                IDLE: begin
                    if (fe) begin
                        op_v   <= sum_v;
                        op_cnt <= cnt;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (op_cnt < 17'(MIN_PIXELS)) begin
                        found <= 1'b0;
                        state <= UPDATE;
                    end else begin
                        found <= 1'b1;
                        state <= DIV_H;
                    end
                end
                DIV_H: begin
                    if (div_done) begin
                        q_h   <= 12'(div_q);
                        state <= DIV_V;
                    end
                end
                DIV_V: if (div_done) state <= UPDATE;
                UPDATE: begin
                    result_stb  <= 1'b1;
                    pixel_count <= op_cnt;
                    ball_found  <= found;
                    if (found) begin
                        center_h <= next_h;
                        center_v <= next_v;
                    end else begin
                        center_h <= CENTER_H_NONE;
                        center_v <= CENTER_V_NONE;
                    end
                    state <= IDLE;
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed self-checking bench for centroid_tracker using compressed frames.
module tb_centroid_tracker;

    logic        PClk;
    logic        Reset;
    logic        Binary_in;
    logic [11:0] VtcHCnt;
    logic [10:0] VtcVCnt;
    logic [11:0] center_h;
    logic [10:0] center_v;
    logic        ball_found;
    logic [16:0] pixel_count;
    logic        result_stb;
    logic        frame_drop;

    int n_cmp;
    int n_fail;

    centroid_tracker dut (
        .PClk        (PClk),
        .Reset       (Reset),
        .Binary_in   (Binary_in),
        .VtcHCnt     (VtcHCnt),
        .VtcVCnt     (VtcVCnt),
        .center_h    (center_h),
        .center_v    (center_v),
        .ball_found  (ball_found),
        .pixel_count (pixel_count),
        .result_stb  (result_stb),
        .frame_drop  (frame_drop)
    );

    initial begin
        PClk = 1'b0;
        forever #5 PClk = ~PClk;
    end

    task automatic tick(input int h, input int v, input logic b);
        VtcHCnt   = h[11:0];
        VtcVCnt   = v[10:0];
        Binary_in = b;
        @(posedge PClk);
        #1;
    endtask

    task automatic idle_tick();
        tick(1, 241, 1'b0);
    endtask

    task automatic blob(input int h0, input int v0, input int w, input int ht);
        for (int v = v0; v < v0 + ht; v++)
            for (int h = h0; h < h0 + w; h++)
                tick(h, v, 1'b1);
    endtask

    // Drives frame end, then counts cycles until result_stb (-1 on timeout).
    task automatic frame_end_wait(output int lat);
        tick(0, 240, 1'b0);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            idle_tick();
            if (result_stb) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) idle_tick();
        n_cmp++; if (center_h !== 12'hFFF) begin n_fail++; $display("FAIL reset center_h got %h want fff", center_h); end
        n_cmp++; if (center_v !== 11'h7FF) begin n_fail++; $display("FAIL reset center_v got %h want 7ff", center_v); end
        n_cmp++; if (ball_found !== 1'b0) begin n_fail++; $display("FAIL reset ball_found got %b want 0", ball_found); end
        n_cmp++; if (pixel_count !== 17'd0) begin n_fail++; $display("FAIL reset pixel_count got %0d want 0", pixel_count); end
        n_cmp++; if (result_stb !== 1'b0) begin n_fail++; $display("FAIL reset result_stb got %b want 0", result_stb); end
        n_cmp++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL reset frame_drop got %b want 0", frame_drop); end
        Reset = 1'b0;
        idle_tick();
    endtask

    task automatic test_blob();
        int lat;
        tick(0, 0, 1'b0);
        blob(100, 50, 5, 5);
        frame_end_wait(lat);
        n_cmp++; if (lat !== 67) begin n_fail++; $display("FAIL blob latency got %0d want 67", lat); end
        n_cmp++; if (center_h !== 12'd102) begin n_fail++; $display("FAIL blob center_h got %0d want 102", center_h); end
        n_cmp++; if (center_v !== 11'd52) begin n_fail++; $display("FAIL blob center_v got %0d want 52", center_v); end
        n_cmp++; if (pixel_count !== 17'd25) begin n_fail++; $display("FAIL blob pixel_count got %0d want 25", pixel_count); end
        n_cmp++; if (ball_found !== 1'b1) begin n_fail++; $display("FAIL blob ball_found got %b want 1", ball_found); end
        n_cmp++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL blob frame_drop got %b want 0", frame_drop); end
        idle_tick();
        n_cmp++; if (result_stb !== 1'b0) begin n_fail++; $display("FAIL blob stb_width got %b want 0", result_stb); end
        n_cmp++; if (center_h !== 12'd102) begin n_fail++; $display("FAIL blob hold center_h got %0d want 102", center_h); end
    endtask

    task automatic test_not_found();
        int lat;
        tick(0, 0, 1'b0);
        blob(30, 60, 5, 2);
        frame_end_wait(lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL nf latency got %0d want 2", lat); end
        n_cmp++; if (ball_found !== 1'b0) begin n_fail++; $display("FAIL nf ball_found got %b want 0", ball_found); end
        n_cmp++; if (center_h !== 12'hFFF) begin n_fail++; $display("FAIL nf center_h got %h want fff", center_h); end
        n_cmp++; if (center_v !== 11'h7FF) begin n_fail++; $display("FAIL nf center_v got %h want 7ff", center_v); end
        n_cmp++; if (pixel_count !== 17'd10) begin n_fail++; $display("FAIL nf pixel_count got %0d want 10", pixel_count); end
        repeat (40) idle_tick();
    endtask

    task automatic test_edges();
        int lat;
        tick(0, 0, 1'b0);
        repeat (8) tick(319, 239, 1'b1);
        repeat (8) tick(0, 239, 1'b1);
        tick(400, 239, 1'b1);
        tick(320, 239, 1'b1);
        tick(5, 241, 1'b1);
        frame_end_wait(lat);
        n_cmp++; if (lat !== 67) begin n_fail++; $display("FAIL edge latency got %0d want 67", lat); end
        n_cmp++; if (center_h !== 12'd159) begin n_fail++; $display("FAIL edge center_h got %0d want 159", center_h); end
        n_cmp++; if (center_v !== 11'd239) begin n_fail++; $display("FAIL edge center_v got %0d want 239", center_v); end
        n_cmp++; if (pixel_count !== 17'd16) begin n_fail++; $display("FAIL edge pixel_count got %0d want 16", pixel_count); end
        n_cmp++; if (ball_found !== 1'b1) begin n_fail++; $display("FAIL edge ball_found got %b want 1", ball_found); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int dummy;
        tick(0, 0, 1'b0);
        frame_end_wait(dummy);
        tick(0, 0, 1'b0);
        blob(10, 200, 5, 5);
        tick(0, 240, 1'b0);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            if (i == 20) tick(0, 240, 1'b0);
            else idle_tick();
            if (result_stb) begin
                lat = i;
                break;
            end
        end
        n_cmp++; if (lat !== 67) begin n_fail++; $display("FAIL b2b latency got %0d want 67", lat); end
        n_cmp++; if (frame_drop !== 1'b1) begin n_fail++; $display("FAIL b2b frame_drop got %b want 1", frame_drop); end
        n_cmp++; if (center_h !== 12'd12) begin n_fail++; $display("FAIL b2b center_h got %0d want 12", center_h); end
        n_cmp++; if (center_v !== 11'd202) begin n_fail++; $display("FAIL b2b center_v got %0d want 202", center_v); end
        n_cmp++; if (pixel_count !== 17'd25) begin n_fail++; $display("FAIL b2b pixel_count got %0d want 25", pixel_count); end
    endtask

    task automatic test_smooth();
        int lat;
        logic [11:0] exp_h;
        logic [10:0] exp_v;
        tick(0, 0, 1'b0);
        frame_end_wait(lat);
        n_cmp++; if (frame_drop !== 1'b1) begin n_fail++; $display("FAIL sticky frame_drop got %b want 1", frame_drop); end
        tick(0, 0, 1'b0);
        repeat (16) tick(100, 20, 1'b1);
        frame_end_wait(lat);
        n_cmp++; if (center_h !== 12'd100) begin n_fail++; $display("FAIL smooth1 center_h got %0d want 100", center_h); end
        n_cmp++; if (center_v !== 11'd20) begin n_fail++; $display("FAIL smooth1 center_v got %0d want 20", center_v); end
        tick(0, 0, 1'b0);
        repeat (16) tick(111, 31, 1'b1);
        frame_end_wait(lat);
`ifdef CENTROID_SMOOTH_EN
        exp_h = 12'd106;
        exp_v = 11'd26;
`else
        exp_h = 12'd111;
        exp_v = 11'd31;
`endif
        n_cmp++; if (lat !== 67) begin n_fail++; $display("FAIL smooth2 latency got %0d want 67", lat); end
        n_cmp++; if (center_h !== exp_h) begin n_fail++; $display("FAIL smooth2 center_h got %0d want %0d", center_h, exp_h); end
        n_cmp++; if (center_v !== exp_v) begin n_fail++; $display("FAIL smooth2 center_v got %0d want %0d", center_v, exp_v); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic stb_seen;
        tick(0, 0, 1'b0);
        tick(50, 100, 1'b1);
        Reset = 1'b1;
        tick(51, 100, 1'b1);
        Reset = 1'b0;
        for (int h = 52; h < 72; h++) tick(h, 100, 1'b1);
        tick(0, 240, 1'b0);
        stb_seen = 1'b0;
        repeat (100) begin
            idle_tick();
            if (result_stb) stb_seen = 1'b1;
        end
        n_cmp++; if (stb_seen !== 1'b0) begin n_fail++; $display("FAIL rmid partial_stb got %b want 0", stb_seen); end
        n_cmp++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL rmid frame_drop got %b want 0", frame_drop); end
        n_cmp++; if (center_h !== 12'hFFF) begin n_fail++; $display("FAIL rmid center_h got %h want fff", center_h); end
        tick(0, 0, 1'b0);
        blob(200, 10, 4, 4);
        frame_end_wait(lat);
        n_cmp++; if (lat !== 67) begin n_fail++; $display("FAIL rmid latency got %0d want 67", lat); end
        n_cmp++; if (center_h !== 12'd201) begin n_fail++; $display("FAIL rmid center_h got %0d want 201", center_h); end
        n_cmp++; if (center_v !== 11'd11) begin n_fail++; $display("FAIL rmid center_v got %0d want 11", center_v); end
        n_cmp++; if (pixel_count !== 17'd16) begin n_fail++; $display("FAIL rmid pixel_count got %0d want 16", pixel_count); end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        Reset     = 1'b1;
        Binary_in = 1'b0;
        VtcHCnt   = 12'd1;
        VtcVCnt   = 11'd241;
        test_reset();
        test_blob();
        test_not_found();
        test_edges();
        test_back_to_back();
        test_smooth();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
